// File: rtl/kyogenrv_avm_pkg.sv
// Shared types and defaults for the KyogenRV Avalon-MM arbiter.
package kyogenrv_avm_pkg;

  localparam int unsigned DefaultAddrW         = 32;
  localparam int unsigned DefaultDataW         = 32;
  localparam int unsigned DefaultStarveMax     = 4;
  localparam int unsigned DefaultTimeoutCycles = 255;

  // Read data returned to a requester whose read timed out (replicated to DATA_W).
  localparam bit TimeoutRdataBit = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RESP,
    DONE
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

endpackage

// File: rtl/kyogenrv_avm_prio.sv
// Grant selection: data side wins unless fetch has been passed over STARVE_MAX times in a row.
module kyogenrv_avm_prio
  import kyogenrv_avm_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DefaultStarveMax
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   grant_fire,
  input  grant_t granted,
  output grant_t grant
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

  logic [CntW-1:0] starve_q, starve_d;

  // Pick the winner from the current requests and the starvation count.
  always_comb begin
    grant = GNT_I;
    if (d_req && ((starve_q < StarveMaxC) || !i_req)) begin
      grant = GNT_D;
    end
  end

  // Count consecutive data grants taken while fetch was waiting; saturate at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!i_req) begin
      starve_d = '0;
    end else if (grant_fire) begin
      if (granted == GNT_I) begin
        starve_d = '0;
      end else if (starve_q < StarveMaxC) begin
        starve_d = starve_q + CntW'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/kyogenrv_avm_arbiter.sv
// Shares one Avalon-MM master between the fetch (read-only) and data requesters.
// One transaction in flight; data has priority with fetch anti-starvation; read timeout.
module kyogenrv_avm_arbiter
  import kyogenrv_avm_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefaultAddrW,
  parameter int unsigned DATA_W         = DefaultDataW,
  parameter int unsigned STARVE_MAX     = DefaultStarveMax,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                cpu_waitrequest,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest,
  output logic                timeout_err
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  grant_t            gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BeW-1:0]    be_q, be_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              err_q, err_d;

  grant_t            grant;
  logic              grant_fire;
  logic              rsp_done;
  logic [DATA_W-1:0] rsp_data;

  assign grant_fire = (state_q == IDLE) && (i_req || d_req);

  kyogenrv_avm_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .d_req     (d_req),
    .grant_fire(grant_fire),
    .granted   (grant),
    .grant     (grant)
  );

  // Transaction FSM: latch the winner's command, hold it through waitrequest, route the response.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    read_d    = read_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    rsp_done  = 1'b0;
    rsp_data  = avm_readdata;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d   = grant;
          state_d = CMD;
          if (grant == GNT_D) begin
            addr_d  = d_addr;
            read_d  = !d_we;
            write_d = d_we;
            wdata_d = d_wdata;
            be_d    = d_be;
          end else begin
            addr_d  = i_addr;
            read_d  = 1'b1;
            write_d = 1'b0;
            wdata_d = '0;
            be_d    = '1;
          end
        end
      end
      CMD: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            d_ack_d = 1'b1;
            state_d = DONE;
          end else begin
            tmo_d = '0;
            // Zero-latency slave: data arrives in the acceptance cycle.
            if (avm_readdatavalid) begin
              rsp_done = 1'b1;
              state_d  = DONE;
            end else begin
              state_d = RESP;
            end
          end
        end
      end
      RESP: begin
        if (avm_readdatavalid) begin
          rsp_done = 1'b1;
          state_d  = DONE;
        end else if (tmo_q == TmoLast) begin
          rsp_done = 1'b1;
          rsp_data = {DATA_W{TimeoutRdataBit}};
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      // Requester's req is still high while its ack is visible, so skip sampling here.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rsp_done) begin
      if (gnt_q == GNT_I) begin
        i_ack_d   = 1'b1;
        i_rdata_d = rsp_data;
      end else begin
        d_ack_d   = 1'b1;
        d_rdata_d = rsp_data;
      end
    end
  end

  // State, bus and response registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_I;
      addr_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  assign avm_address     = addr_q;
  assign avm_read        = read_q;
  assign avm_write       = write_q;
  assign avm_writedata   = wdata_q;
  assign avm_byteenable  = be_q;
  assign i_ack           = i_ack_q;
  assign d_ack           = d_ack_q;
  assign i_rdata         = i_rdata_q;
  assign d_rdata         = d_rdata_q;
  assign timeout_err     = err_q;
  assign cpu_waitrequest = (i_req && !i_ack_q) || (d_req && !d_ack_q);

endmodule

// File: tb/tb_kyogenrv_avm_arbiter.sv
// Self-checking bench for kyogenrv_avm_arbiter: vector table, random traffic, corner sequences.
// Latencies are counted in clock edges from the edge that first samples the request to the
// edge after which the ack is visible (write 2+w, read 2+w+delay, timeout 2+w+TMO).
module tb_kyogenrv_avm_arbiter;

  localparam int SMAX = 4;
  localparam int TMO  = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        i_ack, d_ack, cpu_waitrequest, avm_read, avm_write, timeout_err;
  logic [31:0] i_rdata, d_rdata, avm_address, avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0, avm_waitrequest = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  kyogenrv_avm_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .cpu_waitrequest(cpu_waitrequest),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fmem(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1234};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- slave model ----------------
  int          slv_wait = 0, slv_delay = 1;
  bit          slv_dead = 0, slv_fixed = 0;
  logic [31:0] slv_rdata = '0;
  int          pend = 0, cmd_cycles = 0, cmd_count = 0, last_len = 0, bus_bad = 0;
  logic [31:0] pend_data = '0, last_addr = '0, last_wdata = '0;
  logic [3:0]  last_be = '0;
  bit          last_read = 0, last_write = 0, vis = 0, prev_vis = 0, prev_wait = 0;
  logic [31:0] p_addr = '0, p_wd = '0;
  logic [3:0]  p_be = '0;
  bit          p_rd = 0, p_wr = 0;

  always begin
    @(posedge clock);
    #2;
    avm_readdatavalid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = pend_data;
      end
    end
    vis = avm_read || avm_write;
    avm_waitrequest = 1'b0;
    if (vis) begin
      if (prev_vis) begin
        if (!prev_wait) bus_bad++;
        else if (avm_address !== p_addr || avm_read !== p_rd || avm_write !== p_wr ||
                 avm_writedata !== p_wd || avm_byteenable !== p_be) bus_bad++;
      end else begin
        cmd_count++;
        cmd_cycles = 0;
      end
      cmd_cycles++;
      last_len = cmd_cycles;
      last_addr = avm_address;
      last_wdata = avm_writedata;
      last_be = avm_byteenable;
      last_read = avm_read;
      last_write = avm_write;
      avm_waitrequest = (cmd_cycles <= slv_wait);
      if (!avm_waitrequest && avm_read && !slv_dead) begin
        if (slv_delay == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = slv_fixed ? slv_rdata : fmem(avm_address);
        end else begin
          pend = slv_delay;
          pend_data = slv_fixed ? slv_rdata : fmem(avm_address);
        end
      end
    end
    prev_vis = vis;
    prev_wait = avm_waitrequest;
    p_addr = avm_address;
    p_rd = avm_read;
    p_wr = avm_write;
    p_wd = avm_writedata;
    p_be = avm_byteenable;
  end

  // Drive one or two requests, drop each as its ack appears, record what came back.
  task automatic do_txn(input bit di, input bit dd, input bit we, input logic [31:0] ia,
                        input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be,
                        output int ie, output int de, output logic [31:0] idat,
                        output logic [31:0] ddat, output int ic, output int dc);
    int edge_n = 0;
    int tail = 0;
    int wr_bad = 0;
    ie = -1; de = -1; idat = '0; ddat = '0; ic = 0; dc = 0;
    i_req = di; i_addr = ia; d_req = dd; d_we = we; d_addr = da; d_wdata = wd; d_be = be;
    while (tail < 3 && edge_n < 80) begin
      tick();
      edge_n++;
      if (cpu_waitrequest !== ((i_req && !i_ack) || (d_req && !d_ack))) wr_bad++;
      if (i_ack) begin
        ic++;
        if (ie < 0) begin ie = edge_n; idat = i_rdata; end
        i_req = 1'b0;
      end
      if (d_ack) begin
        dc++;
        if (de < 0) begin de = edge_n; ddat = d_rdata; end
        d_req = 1'b0;
      end
      if (!i_req && !d_req) tail++;
    end
    check("txn_in_budget", tail, 3);
    check("cpu_waitrequest", wr_bad, 0);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          w;
    int          dly;
    logic [31:0] rdata;
    int          exp_edges;
  } vec_t;

  vec_t        vt[6];
  int          ie, de, ic, dc, c0, mode, w, dly, lat_i, lat_d, e_i, e_d;
  logic [31:0] idat, ddat, m_i, m_d, ia, da, wd;
  logic [3:0]  be;
  bit          we, d_first;
  int          m_starve;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 1, 32'h0000_0013, 3};
    vt[1] = '{1'b1, 1'b1, 32'h8000_0004, 32'hCAFE_BABE, 4'b0011, 3, 1, 32'h0, 5};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 0, 32'h1122_3344, 2};
    vt[3] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h5, 1, 2, 32'hDEAD_BEEF, 5};
    vt[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 2, 3, 32'h0050_0093, 7};
    vt[5] = '{1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 0, 1, 32'h0, 2};
    m_i = '0; m_d = '0; m_starve = 0;

    // Reset state.
    reset_n = 1'b0;
    tick(); tick();
    check("rst_avm_read", avm_read, 0);
    check("rst_avm_write", avm_write, 0);
    check("rst_avm_address", avm_address, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_cpu_waitrequest", cpu_waitrequest, 0);
    reset_n = 1'b1;
    tick();

    // Vector table.
    for (int k = 0; k < 6; k++) begin
      slv_wait = vt[k].w; slv_delay = vt[k].dly; slv_fixed = 1; slv_rdata = vt[k].rdata;
      slv_dead = 0;
      c0 = cmd_count;
      do_txn(!vt[k].is_d, vt[k].is_d, vt[k].we, vt[k].addr, vt[k].addr, vt[k].wdata,
             vt[k].be, ie, de, idat, ddat, ic, dc);
      if (vt[k].is_d) begin
        check($sformatf("vec%0d_d_latency", k), de, vt[k].exp_edges);
        check($sformatf("vec%0d_acks", k), {ic[7:0], dc[7:0]}, 16'h0001);
        if (!vt[k].we) begin
          check($sformatf("vec%0d_d_rdata", k), ddat, vt[k].rdata);
          m_d = vt[k].rdata;
        end
      end else begin
        check($sformatf("vec%0d_i_latency", k), ie, vt[k].exp_edges);
        check($sformatf("vec%0d_acks", k), {ic[7:0], dc[7:0]}, 16'h0100);
        check($sformatf("vec%0d_i_rdata", k), idat, vt[k].rdata);
        m_i = vt[k].rdata;
      end
      check($sformatf("vec%0d_cmd_count", k), cmd_count - c0, 1);
      check($sformatf("vec%0d_cmd_len", k), last_len, vt[k].w + 1);
      check($sformatf("vec%0d_cmd_addr", k), last_addr, vt[k].addr);
      check($sformatf("vec%0d_cmd_rw", k), {last_read, last_write},
            (vt[k].is_d && vt[k].we) ? 2'b01 : 2'b10);
      check($sformatf("vec%0d_cmd_be", k), last_be, vt[k].is_d ? vt[k].be : 4'hF);
      if (vt[k].is_d && vt[k].we)
        check($sformatf("vec%0d_cmd_wdata", k), last_wdata, vt[k].wdata);
      check($sformatf("vec%0d_rdata_hold", k), {i_rdata, d_rdata}, {m_i, m_d});
      check($sformatf("vec%0d_no_err", k), timeout_err, 0);
    end

    // Simultaneous reads: data first, fetch after DONE + IDLE.
    slv_wait = 0; slv_delay = 1; slv_fixed = 0;
    do_txn(1, 1, 0, 32'h200, 32'h300, 32'h0, 4'hF, ie, de, idat, ddat, ic, dc);
    check("both_d_latency", de, 3);
    check("both_i_latency", ie, 3 + 1 + 3);
    check("both_ack_counts", {ic[7:0], dc[7:0]}, 16'h0101);
    check("both_i_rdata", idat, fmem(32'h200));
    check("both_d_rdata", ddat, fmem(32'h300));
    m_i = fmem(32'h200); m_d = fmem(32'h300);

    // Randomized traffic against a transaction-level model.
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      w = $urandom_range(0, 3);
      dly = $urandom_range(0, 3);
      we = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      ia = $urandom & 32'hFFFF_FFFC;
      da = $urandom & 32'hFFFF_FFFC;
      wd = $urandom;
      be = 4'($urandom_range(1, 15));
      slv_wait = w; slv_delay = dly; slv_fixed = 0; slv_dead = 0;
      lat_i = 2 + w + dly;
      lat_d = we ? 2 + w : 2 + w + dly;
      do_txn(mode != 1, mode != 0, we, ia, da, wd, be, ie, de, idat, ddat, ic, dc);
      if (mode == 2) begin
        d_first = (m_starve < SMAX);
        e_d = d_first ? lat_d : lat_i + 1 + lat_d;
        e_i = d_first ? lat_d + 1 + lat_i : lat_i;
      end else begin
        e_d = lat_d;
        e_i = lat_i;
      end
      m_starve = 0;
      check($sformatf("rnd%0d_acks", n), {ic[7:0], dc[7:0]},
            {8'(mode != 1), 8'(mode != 0)});
      if (mode != 1) begin
        check($sformatf("rnd%0d_i_latency", n), ie, e_i);
        check($sformatf("rnd%0d_i_rdata", n), idat, fmem(ia));
        m_i = fmem(ia);
      end
      if (mode != 0) begin
        check($sformatf("rnd%0d_d_latency", n), de, e_d);
        if (!we) begin
          check($sformatf("rnd%0d_d_rdata", n), ddat, fmem(da));
          m_d = fmem(da);
        end
      end
      check($sformatf("rnd%0d_rdata_hold", n), {i_rdata, d_rdata}, {m_i, m_d});
    end

    // Starvation: fetch held, data kept requesting back to back.
    begin
      int d_before = 0;
      int d_after = 0;
      int edges = 0;
      bit i_done = 0;
      slv_wait = 0; slv_delay = 1; slv_fixed = 0;
      i_req = 1; i_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h500;
      while (d_after == 0 && edges < 200) begin
        tick();
        edges++;
        if (d_ack) begin
          if (i_done) begin d_after++; d_req = 0; end
          else d_before++;
        end
        if (i_ack) begin
          i_done = 1;
          i_req = 0;
          idat = i_rdata;
        end
      end
      tick(); tick(); tick();
      check("starve_in_budget", edges < 200, 1);
      check("starve_d_before_i", d_before, SMAX);
      check("starve_i_rdata", idat, fmem(32'h400));
      check("starve_d_after_i", d_after, 1);
      m_i = fmem(32'h400); m_d = fmem(32'h500);
      check("starve_rdata_hold", {i_rdata, d_rdata}, {m_i, m_d});
    end

    // Timeout on a dead slave; error flag is sticky.
    slv_dead = 1; slv_wait = 0;
    do_txn(1, 0, 0, 32'h600, 32'h0, 32'h0, 4'h0, ie, de, idat, ddat, ic, dc);
    check("tmo_i_latency", ie, 2 + TMO);
    check("tmo_i_rdata", idat, 0);
    check("tmo_acks", {ic[7:0], dc[7:0]}, 16'h0100);
    check("tmo_err_set", timeout_err, 1);
    slv_dead = 0; slv_delay = 2;
    do_txn(0, 1, 0, 32'h0, 32'h640, 32'h0, 4'hF, ie, de, idat, ddat, ic, dc);
    check("tmo_next_d_latency", de, 4);
    check("tmo_err_sticky", timeout_err, 1);

    // Reset while a read sits in RESP: everything clears, no ack, then normal service.
    slv_dead = 1;
    d_req = 1; d_we = 0; d_addr = 32'h700;
    tick(); tick(); tick(); tick();
    reset_n = 0; d_req = 0;
    tick();
    check("mid_rst_bus", {avm_read, avm_write}, 0);
    check("mid_rst_bus_fields", {avm_address, avm_writedata, avm_byteenable}, 0);
    check("mid_rst_acks", {i_ack, d_ack}, 0);
    check("mid_rst_rdata", {i_rdata, d_rdata}, 0);
    check("mid_rst_err", timeout_err, 0);
    reset_n = 1;
    begin
      int stray = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (i_ack || d_ack || avm_read || avm_write) stray++;
      end
      check("mid_rst_quiet", stray, 0);
    end
    slv_dead = 0;
    do_txn(0, 1, 1, 32'h0, 32'h780, 32'hA5A5_0F0F, 4'b1100, ie, de, idat, ddat, ic, dc);
    check("post_rst_write_latency", de, 2);
    check("post_rst_write_acks", {ic[7:0], dc[7:0]}, 16'h0001);
    check("post_rst_wdata", last_wdata, 32'hA5A5_0F0F);

    check("bus_protocol", bus_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
